// File: rtl/prei_md_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prei_md_ram_ctrl : round-robin arbiter and initialiser for the 85x6 intra
//                    mode RAM (one mode per 4x4/8x8/16x16/32x32 block).
// Revision 1.0
// ---------------------------------------------------------------------------
module prei_md_ram_ctrl #(
  parameter int                ADR_WD  = 7,
  parameter int                ADR     = 85,
  parameter int                DAT_WD  = 6,
  parameter logic [DAT_WD-1:0] CLR_VAL = 6'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start_i,
  output logic              clr_done_o,
  output logic              busy_o,
  input  logic              wr_req_i,
  input  logic [ADR_WD-1:0] wr_adr_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADR_WD-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam logic [ADR_WD-1:0] ADR_LIM  = ADR_WD'(ADR);
  localparam logic [ADR_WD-1:0] ADR_LAST = ADR_WD'(ADR - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_t;

  state_t            state;
  logic [ADR_WD-1:0] clr_cnt;
  logic              last_wr;
  logic              clr_done;
  logic              rd_val;
  logic              rd_oor;

  logic wr_gnt;
  logic rd_gnt;
  logic wr_in_rng;
  logic rd_in_rng;

  assign wr_in_rng = (wr_adr_i < ADR_LIM);
  assign rd_in_rng = (rd_adr_i < ADR_LIM);

  // Grants are gated by rst so the acks read as reset values while rst is high.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!rst && state == IDLE && !clr_start_i) begin
      if (wr_req_i && (!rd_req_i || !last_wr)) begin
        wr_gnt = 1'b1;
      end else if (rd_req_i) begin
        rd_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_adr_o    = '0;
    ram_wr_ena_o = 1'b1;
    ram_rd_ena_o = 1'b1;
    ram_wr_dat_o = '0;
    if (state == CLR) begin
      ram_adr_o    = clr_cnt;
      ram_wr_ena_o = 1'b0;
      ram_wr_dat_o = CLR_VAL;
    end else if (wr_gnt && wr_in_rng) begin
      ram_adr_o    = wr_adr_i;
      ram_wr_ena_o = 1'b0;
      ram_wr_dat_o = wr_dat_i;
    end else if (rd_gnt && rd_in_rng) begin
      ram_adr_o    = rd_adr_i;
      ram_rd_ena_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      last_wr  <= 1'b0;
      clr_done <= 1'b0;
      rd_val   <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      rd_val   <= rd_gnt;
      rd_oor   <= rd_gnt && !rd_in_rng;
      if (wr_gnt) begin
        last_wr <= 1'b1;
      end else if (rd_gnt) begin
        last_wr <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (clr_start_i) begin
            state   <= CLR;
            clr_cnt <= '0;
          end
        end
        CLR: begin
          if (clr_cnt == ADR_LAST) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_ack_o   = wr_gnt;
  assign rd_ack_o   = rd_gnt;
  assign busy_o     = (state == CLR);
  assign clr_done_o = clr_done;
  assign rd_val_o   = rd_val;
  // Out-of-range reads still return a valid beat, but with zero data.
  assign rd_dat_o   = (rd_val && !rd_oor) ? ram_rd_dat_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_prei_md_ram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prei_md_ram_ctrl : directed bench with a behavioural 85x6 RAM model.
// ---------------------------------------------------------------------------
module tb_prei_md_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_start_i;
  logic       clr_done_o;
  logic       busy_o;
  logic       wr_req_i;
  logic [6:0] wr_adr_i;
  logic [5:0] wr_dat_i;
  logic       wr_ack_o;
  logic       rd_req_i;
  logic [6:0] rd_adr_i;
  logic       rd_ack_o;
  logic       rd_val_o;
  logic [5:0] rd_dat_o;
  logic [6:0] ram_adr_o;
  logic       ram_wr_ena_o;
  logic [5:0] ram_wr_dat_o;
  logic       ram_rd_ena_o;
  logic [5:0] ram_rd_dat_i;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_low = 0;
  int en_low = 0;
  int done_cnt;
  logic [5:0] mem [0:127];

  prei_md_ram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .clr_start_i (clr_start_i),
    .clr_done_o  (clr_done_o),
    .busy_o      (busy_o),
    .wr_req_i    (wr_req_i),
    .wr_adr_i    (wr_adr_i),
    .wr_dat_i    (wr_dat_i),
    .wr_ack_o    (wr_ack_o),
    .rd_req_i    (rd_req_i),
    .rd_adr_i    (rd_adr_i),
    .rd_ack_o    (rd_ack_o),
    .rd_val_o    (rd_val_o),
    .rd_dat_o    (rd_dat_o),
    .ram_adr_o   (ram_adr_o),
    .ram_wr_ena_o(ram_wr_ena_o),
    .ram_wr_dat_o(ram_wr_dat_o),
    .ram_rd_ena_o(ram_rd_ena_o),
    .ram_rd_dat_i(ram_rd_dat_i)
  );

  always #5 clk = ~clk;

  // RAM wrapper model: write at the edge, read data registered one cycle later.
  always @(posedge clk) begin
    if (!ram_wr_ena_o) mem[ram_adr_o] <= ram_wr_dat_o;
    if (!ram_rd_ena_o) ram_rd_dat_i <= mem[ram_adr_o];
  end

  always @(negedge clk) begin
    if (!ram_wr_ena_o) wr_low++;
    if (!ram_wr_ena_o || !ram_rd_ena_o) en_low++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    clr_start_i = 1'b0;
    wr_req_i    = 1'b0;
    wr_adr_i    = '0;
    wr_dat_i    = '0;
    rd_req_i    = 1'b0;
    rd_adr_i    = '0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 6'h2A;
    ram_rd_dat_i = 6'h2A;
    idle_in();
    rst = 1'b1;
    wr_req_i = 1'b1;
    wr_adr_i = 7'd3;
    rd_req_i = 1'b1;
    rd_adr_i = 7'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_wr_ack", wr_ack_o, 0);
    chk("rst_rd_ack", rd_ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", clr_done_o, 0);
    chk("rst_rd_val", rd_val_o, 0);
    chk("rst_rd_dat", rd_dat_o, 0);
    chk("rst_ram_adr", ram_adr_o, 0);
    chk("rst_wr_ena", ram_wr_ena_o, 1);
    chk("rst_rd_ena", ram_rd_ena_o, 1);
    chk("rst_wr_dat", ram_wr_dat_o, 0);
    next_cyc();
    idle_in();
    rst = 1'b0;
    next_cyc();

    // Write entry 5 = 26, then read it back
    wr_low = 0;
    wr_req_i = 1'b1; wr_adr_i = 7'd5; wr_dat_i = 6'd26;
    @(negedge clk);
    chk("w5_ack", wr_ack_o, 1);
    chk("w5_rd_ack", rd_ack_o, 0);
    chk("w5_ena", ram_wr_ena_o, 0);
    chk("w5_adr", ram_adr_o, 5);
    chk("w5_dat", ram_wr_dat_o, 26);
    next_cyc();
    wr_req_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = 7'd5;
    @(negedge clk);
    chk("r5_ack", rd_ack_o, 1);
    chk("r5_rd_ena", ram_rd_ena_o, 0);
    chk("r5_wr_ena", ram_wr_ena_o, 1);
    chk("r5_adr", ram_adr_o, 5);
    chk("r5_val_early", rd_val_o, 0);
    next_cyc();
    rd_req_i = 1'b0;
    @(negedge clk);
    chk("r5_val", rd_val_o, 1);
    chk("r5_dat", rd_dat_o, 26);
    chk("r5_ack_drop", rd_ack_o, 0);
    next_cyc();
    @(negedge clk);
    chk("r5_val_end", rd_val_o, 0);
    chk("r5_dat_end", rd_dat_o, 0);
    chk("w5_one_cycle", wr_low, 1);

    // Contention: write first, then alternate
    next_cyc();
    wr_req_i = 1'b1; wr_adr_i = 7'd12; wr_dat_i = 6'd9;
    rd_req_i = 1'b1; rd_adr_i = 7'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_wr_ack", wr_ack_o, (i % 2 == 0) ? 1 : 0);
      chk("rr_rd_ack", rd_ack_o, (i % 2 == 1) ? 1 : 0);
      chk("rr_rd_val", rd_val_o, (i == 2) ? 1 : 0);
      if (i == 2) chk("rr_rd_dat", rd_dat_o, 6'h2A);
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    chk("rr_rd_val_last", rd_val_o, 1);
    chk("rr_rd_dat_last", rd_dat_o, 6'h2A);

    // Initialise with a write request pending from the start cycle
    next_cyc();
    clr_start_i = 1'b1;
    wr_req_i = 1'b1; wr_adr_i = 7'd20; wr_dat_i = 6'd33;
    @(negedge clk);
    chk("cs_wr_ack", wr_ack_o, 0);
    chk("cs_busy", busy_o, 0);
    chk("cs_wr_ena", ram_wr_ena_o, 1);
    next_cyc();
    clr_start_i = 1'b0;
    for (int k = 0; k < 85; k++) begin
      @(negedge clk);
      chk("clr_busy", busy_o, 1);
      chk("clr_adr", ram_adr_o, k);
      chk("clr_wr_ena", ram_wr_ena_o, 0);
      chk("clr_wr_dat", ram_wr_dat_o, 1);
      chk("clr_wr_ack", wr_ack_o, 0);
      chk("clr_done_early", clr_done_o, 0);
      next_cyc();
    end
    @(negedge clk);
    chk("clr_done", clr_done_o, 1);
    chk("clr_busy_off", busy_o, 0);
    chk("clr_wr_ack_after", wr_ack_o, 1);
    chk("clr_wr_adr_after", ram_adr_o, 20);
    next_cyc();
    wr_req_i = 1'b0;
    @(negedge clk);
    chk("clr_done_pulse", clr_done_o, 0);
    for (int k = 0; k < 86; k++) begin
      next_cyc();
      rd_req_i = (k < 85);
      rd_adr_i = 7'(k);
      @(negedge clk);
      if (k < 85) chk("all_rd_ack", rd_ack_o, 1);
      if (k > 0) begin
        chk("all_rd_val", rd_val_o, 1);
        chk("all_rd_dat", rd_dat_o, (k - 1 == 20) ? 33 : 1);
      end
    end

    // Out-of-range write and read
    next_cyc();
    idle_in();
    en_low = 0;
    wr_req_i = 1'b1; wr_adr_i = 7'd85; wr_dat_i = 6'd7;
    @(negedge clk);
    chk("oor_wr_ack", wr_ack_o, 1);
    next_cyc();
    wr_req_i = 1'b0; rd_req_i = 1'b1; rd_adr_i = 7'd85;
    @(negedge clk);
    chk("oor_rd_ack", rd_ack_o, 1);
    next_cyc();
    rd_req_i = 1'b0;
    @(negedge clk);
    chk("oor_rd_val", rd_val_o, 1);
    chk("oor_rd_dat", rd_dat_o, 0);
    chk("oor_no_ena", en_low, 0);
    next_cyc();
    rd_req_i = 1'b1; rd_adr_i = 7'd84;
    next_cyc();
    rd_req_i = 1'b0;
    @(negedge clk);
    chk("e84_dat", rd_dat_o, 1);

    // Reset with a read beat pending
    next_cyc();
    rd_req_i = 1'b1; rd_adr_i = 7'd3;
    next_cyc();
    rd_req_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstv_rd_val", rd_val_o, 0);
    chk("rstv_rd_dat", rd_dat_o, 0);
    next_cyc();
    rst = 1'b0;

    // Reset at cycle 40 of CLR
    next_cyc();
    clr_start_i = 1'b1;
    next_cyc();
    clr_start_i = 1'b0;
    repeat (39) next_cyc();
    @(negedge clk);
    chk("c40_adr", ram_adr_o, 39);
    #2;
    rst = 1'b1;
    #1;
    chk("c40_busy", busy_o, 0);
    chk("c40_wr_ena", ram_wr_ena_o, 1);
    chk("c40_rd_ena", ram_rd_ena_o, 1);
    chk("c40_adr_rst", ram_adr_o, 0);
    chk("c40_wr_dat", ram_wr_dat_o, 0);
    chk("c40_done", clr_done_o, 0);
    next_cyc();
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (clr_done_o) done_cnt++;
    end
    chk("c40_no_done", done_cnt, 0);
    chk("c40_idle", busy_o, 0);
    next_cyc();
    clr_start_i = 1'b1;
    next_cyc();
    clr_start_i = 1'b0;
    @(negedge clk);
    chk("re_busy", busy_o, 1);
    chk("re_adr0", ram_adr_o, 0);
    next_cyc();
    @(negedge clk);
    chk("re_adr1", ram_adr_o, 1);
    done_cnt = 0;
    for (int k = 0; k < 120 && done_cnt == 0; k++) begin
      next_cyc();
      @(negedge clk);
      if (clr_done_o) done_cnt = k + 3;
    end
    chk("re_done_cycle", done_cnt, 86);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
